counter_nbit_mode: RTL and testbench

- Parametrised, multi-mode successor to the team's 4-bit clearable counter.
- Registered count of WIDTH bits with programmable top value MAX_COUNT.
- Supports synchronous load, count enable, and four count modes: up-wrap, down-wrap, triangle (up/down bounce) and up-saturate.
- Drives the waveform-generator datapath: q is the sample index/amplitude, tc marks period/half-period boundaries.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_next_state.sv | 70 +++++++
 rtl/counter_nbit_mode.sv | 62 ++++++
 tb/tb_counter_nbit_mode.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the multi-mode counter family: count modes and the
// direction flag values used on the dir output.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP_WRAP   = 2'b00,
        MODE_DOWN_WRAP = 2'b01,
        MODE_TRIANGLE  = 2'b10,
        MODE_UP_SAT    = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_next_state.sv
// Combinational successor function of the counter: given the current count,
// direction and mode, computes the count, direction and tc of the next edge.
module counter_next_state
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_q,
    output logic             next_dir,
    output logic             next_tc
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

    logic at_max;
    logic at_zero;

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == ZERO_Q);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        next_q   = q;
        next_dir = dir;
        next_tc  = 1'b0;
        case (mode_e'(mode))
            MODE_UP_WRAP: begin
                next_q   = at_max ? ZERO_Q : q + ONE_Q;
                next_dir = DIR_UP;
                next_tc  = (next_q == MAX_Q);
            end
            MODE_DOWN_WRAP: begin
                next_q   = at_zero ? MAX_Q : q - ONE_Q;
                next_dir = DIR_DOWN;
                next_tc  = (next_q == ZERO_Q);
            end
            MODE_TRIANGLE: begin
                // Bounce off each endpoint so it is visited once per period.
                if (dir == DIR_UP) begin
                    if (at_max) begin
                        next_q   = MAX_Q - ONE_Q;
                        next_dir = DIR_DOWN;
                    end else begin
                        next_q = q + ONE_Q;
                    end
                end else begin
                    if (at_zero) begin
                        next_q   = ONE_Q;
                        next_dir = DIR_UP;
                    end else begin
                        next_q = q - ONE_Q;
                    end
                end
                next_tc = (next_q == MAX_Q) || (next_q == ZERO_Q);
            end
            MODE_UP_SAT: begin
                next_q   = at_max ? MAX_Q : q + ONE_Q;
                next_dir = DIR_UP;
                next_tc  = !at_max && (next_q == MAX_Q);
            end
        endcase
    end

endmodule

// File: rtl/counter_nbit_mode.sv
// Parametrised multi-mode counter: registered q/dir/tc with clamped load,
// count enable and four count modes (up-wrap, down-wrap, triangle, up-saturate).
module counter_nbit_mode
    import counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MAX_COUNT   = 2**WIDTH - 1,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] load_q;
    logic             next_dir;
    logic             next_tc;

    counter_next_state #(
        .WIDTH    (WIDTH),
        .MAX_COUNT(MAX_COUNT)
    ) u_next_state (
        .q       (q),
        .dir     (dir),
        .mode    (mode),
        .next_q  (next_q),
        .next_dir(next_dir),
        .next_tc (next_tc)
    );

    // Out-of-range loads clamp so q can never exceed MAX_COUNT.
    assign load_q = (load_value > MAX_Q) ? MAX_Q : load_value;

    // NOTE: state registers use non-blocking assignments so all three update together at the edge.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q   <= RESET_Q;
            dir <= DIR_UP;
            tc  <= 1'b0;
        end else if (load) begin
            q  <= load_q;
            tc <= 1'b0;
        end else if (enable) begin
            q   <= next_q;
            dir <= next_dir;
            tc  <= next_tc;
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_nbit_mode.sv
// Self-checking bench for counter_nbit_mode: directed scenarios plus a
// randomized run against a behavioural model of the counting rules.
module tb_counter_nbit_mode;

    localparam int W  = 4;
    localparam int M  = 9;
    localparam int W8 = 8;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [W-1:0]  load_value = '0;
    logic [W-1:0]  q;
    logic          dir;
    logic          tc;

    logic          enable8 = 1'b0;
    logic          load8 = 1'b0;
    logic [1:0]    mode8 = 2'b00;
    logic [W8-1:0] load_value8 = '0;
    logic [W8-1:0] q8;
    logic          dir8;
    logic          tc8;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state (plain integers).
    int mq   = 0;
    int mdir = 0;
    int mtc  = 0;

    counter_nbit_mode #(.WIDTH(W), .MAX_COUNT(M), .RESET_VALUE(0)) dut (
        .clock     (clock),
        .clear     (clear),
        .enable    (enable),
        .mode      (mode),
        .load      (load),
        .load_value(load_value),
        .q         (q),
        .dir       (dir),
        .tc        (tc)
    );

    counter_nbit_mode #(.WIDTH(W8), .MAX_COUNT(255), .RESET_VALUE(0)) dut8 (
        .clock     (clock),
        .clear     (clear),
        .enable    (enable8),
        .mode      (mode8),
        .load      (load8),
        .load_value(load_value8),
        .q         (q8),
        .dir       (dir8),
        .tc        (tc8)
    );

    always #5 clock = ~clock;

    task automatic model_edge();
        if (load) begin
            mq  = (int'(load_value) > M) ? M : int'(load_value);
            mtc = 0;
        end else if (!enable) begin
            mtc = 0;
        end else begin
            case (mode)
                2'd0: begin mq = (mq + 1) % (M + 1); mdir = 0; mtc = (mq == M); end
                2'd1: begin mq = (mq + M) % (M + 1); mdir = 1; mtc = (mq == 0); end
                2'd2: begin
                    if (mdir == 0 && mq == M) mdir = 1;
                    else if (mdir == 1 && mq == 0) mdir = 0;
                    mq  = mq + ((mdir != 0) ? -1 : 1);
                    mtc = (mq == 0 || mq == M);
                end
                default: begin mtc = (mq == M - 1); mq = (mq < M) ? mq + 1 : M; mdir = 0; end
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #1 clear = 1'b0;
        #1;
        checks++;
        if (q !== 4'd0 || dir !== 1'b0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial q=%0d dir=%0d tc=%0d expected 0/0/0", q, dir, tc);
        end
        #1 clear = 1'b1;
        mq = 0; mdir = 0; mtc = 0;
        // Reach q=5 counting down so dir is 1 when clear hits.
        load = 1'b1; load_value = 4'd6;
        cycle();
        load = 1'b0; mode = 2'd1; enable = 1'b1;
        cycle();
        checks++;
        if (q !== 4'd5 || dir !== 1'b1) begin
            failures++;
            $display("FAIL reset_setup q=%0d dir=%0d expected 5/1", q, dir);
        end
        #2 clear = 1'b0;
        #1;
        checks++;
        if (q !== 4'd0 || dir !== 1'b0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL reset_midcount q=%0d dir=%0d tc=%0d expected 0/0/0", q, dir, tc);
        end
        mq = 0; mdir = 0; mtc = 0;
        #1 clear = 1'b1;
        mode = 2'd0;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            checks++;
            if (q !== W'(i)) begin
                failures++;
                $display("FAIL reset_release[%0d] q=%0d expected %0d", i, q, i);
            end
        end
    endtask

    task automatic test_up_wrap();
        load = 1'b1; load_value = 4'd0;
        cycle();
        load = 1'b0; mode = 2'd0; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int e;
            e = (i + 1) % 10;
            cycle();
            checks++;
            if (q !== W'(e) || tc !== (e == 9) || dir !== 1'b0) begin
                failures++;
                $display("FAIL up_wrap[%0d] q=%0d tc=%0d dir=%0d expected q=%0d tc=%0d dir=0",
                         i, q, tc, dir, e, (e == 9));
            end
        end
    endtask

    task automatic test_triangle();
        load = 1'b1; load_value = 4'd0;
        cycle();
        load = 1'b0; mode = 2'd2;
        for (int s = 1; s <= 20; s++) begin
            int e;
            logic ed;
            e  = (s <= 9) ? s : (s <= 18) ? 18 - s : s - 18;
            ed = (s >= 10 && s <= 18);
            cycle();
            checks++;
            if (q !== W'(e) || dir !== ed || tc !== (e == 0 || e == 9)) begin
                failures++;
                $display("FAIL triangle[%0d] q=%0d dir=%0d tc=%0d expected q=%0d dir=%0d tc=%0d",
                         s, q, dir, tc, e, ed, (e == 0 || e == 9));
            end
        end
    endtask

    task automatic test_saturate();
        int exp_q[5] = '{8, 9, 9, 9, 9};
        load = 1'b1; load_value = 4'd7;
        cycle();
        load = 1'b0; mode = 2'd3;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (q !== W'(exp_q[i]) || tc !== (i == 1)) begin
                failures++;
                $display("FAIL saturate[%0d] q=%0d tc=%0d expected q=%0d tc=%0d",
                         i, q, tc, exp_q[i], (i == 1));
            end
        end
        mode = 2'd1;
        cycle();
        checks++;
        if (q !== 4'd8 || dir !== 1'b1 || tc !== 1'b0) begin
            failures++;
            $display("FAIL sat_to_down q=%0d dir=%0d tc=%0d expected 8/1/0", q, dir, tc);
        end
    endtask

    task automatic test_load_clamp();
        load = 1'b1; load_value = 4'd4;
        cycle();
        checks++;
        if (q !== 4'd4 || dir !== 1'b1) begin
            failures++;
            $display("FAIL load_plain q=%0d dir=%0d expected 4/1", q, dir);
        end
        load_value = 4'd13;
        cycle();
        checks++;
        if (q !== 4'd9 || tc !== 1'b0 || dir !== 1'b1) begin
            failures++;
            $display("FAIL load_clamp q=%0d tc=%0d dir=%0d expected 9/0/1", q, tc, dir);
        end
        load = 1'b0; mode = 2'd0;
        cycle();
        checks++;
        if (q !== 4'd0 || tc !== 1'b0 || dir !== 1'b0) begin
            failures++;
            $display("FAIL load_then_wrap q=%0d tc=%0d dir=%0d expected 0/0/0", q, tc, dir);
        end
    endtask

    task automatic test_hold_and_wide();
        load = 1'b1; load_value = 4'd8;
        cycle();
        load = 1'b0; mode = 2'd0; enable = 1'b1;
        cycle();
        checks++;
        if (q !== 4'd9 || tc !== 1'b1) begin
            failures++;
            $display("FAIL hold_setup q=%0d tc=%0d expected 9/1", q, tc);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (q !== 4'd9 || tc !== 1'b0 || dir !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d] q=%0d tc=%0d dir=%0d expected 9/0/0", i, q, tc, dir);
            end
        end
        load8 = 1'b1; load_value8 = 8'd0;
        @(posedge clock); #1;
        load8 = 1'b0; mode8 = 2'd1; enable8 = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (q8 !== 8'd255 || tc8 !== 1'b0 || dir8 !== 1'b1) begin
            failures++;
            $display("FAIL wide_down_wrap q=%0d tc=%0d dir=%0d expected 255/0/1", q8, tc8, dir8);
        end
        @(posedge clock); #1;
        checks++;
        if (q8 !== 8'd254) begin
            failures++;
            $display("FAIL wide_down_step q=%0d expected 254", q8);
        end
        enable8 = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load       = ($urandom_range(7) == 0);
            load_value = W'($urandom_range(15));
            enable     = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            cycle();
            checks++;
            if (q !== W'(mq) || dir !== mdir[0] || tc !== mtc[0]) begin
                failures++;
                $display("FAIL random[%0d] q=%0d dir=%0d tc=%0d expected q=%0d dir=%0d tc=%0d",
                         i, q, dir, tc, mq, mdir, mtc);
            end
            if ($urandom_range(63) == 0) begin
                clear = 1'b0;
                #1;
                checks++;
                if (q !== 4'd0 || dir !== 1'b0 || tc !== 1'b0) begin
                    failures++;
                    $display("FAIL random_clear[%0d] q=%0d dir=%0d tc=%0d expected 0/0/0", i, q, dir, tc);
                end
                mq = 0; mdir = 0; mtc = 0;
                clear = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_triangle();
        test_saturate();
        test_load_clamp();
        test_hold_and_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
